// File: rtl/life_window_if.sv
//------------------------------------------------------------------------------
// life_window_if
// Load-stream and neighbourhood-window handshake bundle for life_window.
// The slave modport is the life_window side; the master modport is the
// producer of load cells and consumer of windows.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface life_window_if #(
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
);
  logic             in_valid;
  logic             in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             c, l, r, u, d, lu, ld, ru, rd;
  logic [LOG2X-1:0] out_x;
  logic [LOG2Y-1:0] out_y;
  logic             out_last;
  logic             frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, c, l, r, u, d, lu, ld, ru, rd,
    input  out_x, out_y, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, c, l, r, u, d, lu, ld, ru, rd,
    output out_x, out_y, out_last, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/life_window.sv
//------------------------------------------------------------------------------
// life_window
// Frame-buffered 3x3 neighbourhood generator. Loads one X*Y generation as a
// row-major serial stream, then presents every cell with its eight neighbours
// in row-major order on a valid/ready handshake.
// Optional feature macro: LIFE_WRAP_EN (toroidal edges; default dead edges).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module life_window #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  life_window_if.slave  bus
);

  localparam int               IDXW   = $clog2(X * Y);
  localparam logic [LOG2X-1:0] c_XMAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] c_YMAX = LOG2Y'(Y - 1);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           r_state, w_next;
  logic [X*Y-1:0]   r_frame;
  logic [LOG2X-1:0] r_lx, r_sx;
  logic [LOG2Y-1:0] r_ly, r_sy;
  logic             r_frame_done;

  logic             w_in_ready, w_out_valid;
  logic             w_load_fire, w_scan_fire;
  logic             w_lx_end, w_ly_end, w_sx_end, w_sy_end;
  logic [LOG2X-1:0] w_xm, w_xp;
  logic [LOG2Y-1:0] w_ym, w_yp;
  logic             w_xm_ok, w_xp_ok, w_ym_ok, w_yp_ok;

  // Linear row-major index of cell (x, y); X need not be a power of two.
  function automatic logic [IDXW-1:0] f_idx(input logic [LOG2X-1:0] x,
                                            input logic [LOG2Y-1:0] y);
    return IDXW'(y) * IDXW'(X) + IDXW'(x);
  endfunction

  // Cell value, forced to 0 when the neighbour lies off the frame.
  function automatic logic f_cell(input logic [LOG2X-1:0] x,
                                  input logic [LOG2Y-1:0] y,
                                  input logic             ok);
    return ok & r_frame[f_idx(x, y)];
  endfunction

  assign w_load_fire = w_in_ready & bus.in_valid;
  assign w_scan_fire = w_out_valid & bus.out_ready;
  assign w_lx_end    = (r_lx == c_XMAX);
  assign w_ly_end    = (r_ly == c_YMAX);
  assign w_sx_end    = (r_sx == c_XMAX);
  assign w_sy_end    = (r_sy == c_YMAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (w_load_fire && w_lx_end && w_ly_end) w_next = S_SCAN;
      end
      S_SCAN: begin
        w_out_valid = 1'b1;
        if (w_scan_fire && w_sx_end && w_sy_end) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // Load position counter; column wraps at X-1 into the next row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lx <= '0;
      r_ly <= '0;
    end else if (w_load_fire) begin
      if (w_lx_end) begin
        r_lx <= '0;
        r_ly <= w_ly_end ? '0 : r_ly + LOG2Y'(1);
      end else begin
        r_lx <= r_lx + LOG2X'(1);
      end
    end
  end

  // Scan position counter; advances only on an accepted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (w_scan_fire) begin
      if (w_sx_end) begin
        r_sx <= '0;
        r_sy <= w_sy_end ? '0 : r_sy + LOG2Y'(1);
      end else begin
        r_sx <= r_sx + LOG2X'(1);
      end
    end
  end

  // Frame store, written only by accepted load cells.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_frame <= '0;
    else if (w_load_fire) r_frame[f_idx(r_lx, r_ly)] <= bus.in_data;
  end

  // One-cycle completion pulse coinciding with the return to LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_done <= 1'b0;
    else        r_frame_done <= w_scan_fire & w_sx_end & w_sy_end;
  end

  // Neighbour coordinates with edge handling; the wrapped coordinate is
  // computed in both builds and simply masked off in the dead-edge build.
  always_comb begin
    w_xm = w_sx_end ? c_XMAX : c_XMAX;
    w_xm = (r_sx == '0) ? c_XMAX : r_sx - LOG2X'(1);
    w_xp = w_sx_end ? '0 : r_sx + LOG2X'(1);
    w_ym = (r_sy == '0) ? c_YMAX : r_sy - LOG2Y'(1);
    w_yp = w_sy_end ? '0 : r_sy + LOG2Y'(1);
`ifdef LIFE_WRAP_EN
    w_xm_ok = 1'b1;
    w_xp_ok = 1'b1;
    w_ym_ok = 1'b1;
    w_yp_ok = 1'b1;
`else
    w_xm_ok = (r_sx != '0);
    w_xp_ok = !w_sx_end;
    w_ym_ok = (r_sy != '0);
    w_yp_ok = !w_sy_end;
`endif
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_x      = r_sx;
  assign bus.out_y      = r_sy;
  assign bus.out_last   = w_out_valid & w_sx_end & w_sy_end;
  assign bus.frame_done = r_frame_done;

  // Window bits are held at 0 outside SCAN.
  assign bus.c  = w_out_valid & f_cell(r_sx, r_sy, 1'b1);
  assign bus.l  = w_out_valid & f_cell(w_xm, r_sy, w_xm_ok);
  assign bus.r  = w_out_valid & f_cell(w_xp, r_sy, w_xp_ok);
  assign bus.u  = w_out_valid & f_cell(r_sx, w_ym, w_ym_ok);
  assign bus.d  = w_out_valid & f_cell(r_sx, w_yp, w_yp_ok);
  assign bus.lu = w_out_valid & f_cell(w_xm, w_ym, w_xm_ok & w_ym_ok);
  assign bus.ld = w_out_valid & f_cell(w_xm, w_yp, w_xm_ok & w_yp_ok);
  assign bus.ru = w_out_valid & f_cell(w_xp, w_ym, w_xp_ok & w_ym_ok);
  assign bus.rd = w_out_valid & f_cell(w_xp, w_yp, w_xp_ok & w_yp_ok);

endmodule

`default_nettype wire

// File: tb/tb_life_window.sv
//------------------------------------------------------------------------------
// tb_life_window
// Self-checking bench for life_window: an 8x8 instance and a 5x3 instance,
// checked against a coordinate-arithmetic model of the neighbourhood.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_life_window;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  life_window_if #(.LOG2X(3), .LOG2Y(3)) ia ();
  life_window_if #(.LOG2X(3), .LOG2Y(2)) ib ();

  life_window #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  life_window #(.X(5), .Y(3), .LOG2X(3), .LOG2Y(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  int       n_vec = 0;
  int       n_err = 0;
  int       gw = 8;
  int       gh = 8;
  bit       mf [64];
  bit [8:0] cap [64];

  // Model cell lookup from plain coordinates.
  function automatic bit nb(input int x, input int y);
`ifdef LIFE_WRAP_EN
    x = (x + gw) % gw;
    y = (y + gh) % gh;
`else
    if (x < 0 || x >= gw || y < 0 || y >= gh) return 1'b0;
`endif
    return mf[y * gw + x];
  endfunction

  // Expected {c,l,r,u,d,lu,ld,ru,rd} for centre (x, y).
  function automatic bit [8:0] ref_win(input int x, input int y);
    return {nb(x, y), nb(x-1, y), nb(x+1, y), nb(x, y-1), nb(x, y+1),
            nb(x-1, y-1), nb(x-1, y+1), nb(x+1, y-1), nb(x+1, y+1)};
  endfunction

  task automatic load_a(input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < 64 && cyc < 400) begin
      @(negedge clk);
      n_vec++;
      if ({ia.in_ready, ia.out_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL load_hs k=%0d got rdy/vld=%b%b want 10", k, ia.in_ready, ia.out_valid);
      end
      ia.in_valid = !(gaps && (cyc % 3 == 2));
      ia.in_data  = mf[k];
      if (ia.in_valid) k++;
      cyc++;
    end
    n_vec++;
    if (k < 64) begin n_err++; $display("FAIL load_timeout got %0d cells want 64", k); end
  endtask

  // rmode: 0 ready high, 1 ready 0101..., 2 random. abort_at >= 0 resets there.
  task automatic scan_a(input int rmode, input int abort_at, output int cycles);
    int pos = 0;
    int cyc = 0;
    bit ready;
    bit [8:0] got;
    while (pos < 64 && cyc < 1000) begin
      @(negedge clk);
      got = {ia.c, ia.l, ia.r, ia.u, ia.d, ia.lu, ia.ld, ia.ru, ia.rd};
      n_vec += 3;
      if ({ia.out_valid, ia.in_ready, ia.out_last, ia.frame_done} !== {3'b10, pos == 63, 1'b0}) begin
        n_err++;
        $display("FAIL scan_status pos=%0d got %b%b%b%b want 10%b0", pos, ia.out_valid,
                 ia.in_ready, ia.out_last, ia.frame_done, pos == 63);
      end
      if (ia.out_x !== 3'(pos % 8) || ia.out_y !== 3'(pos / 8)) begin
        n_err++;
        $display("FAIL scan_xy got (%0d,%0d) want (%0d,%0d)", ia.out_x, ia.out_y, pos % 8, pos / 8);
      end
      if (got !== ref_win(pos % 8, pos / 8)) begin
        n_err++;
        $display("FAIL scan_win pos=%0d got %b want %b", pos, got, ref_win(pos % 8, pos / 8));
      end
      if (pos == abort_at) begin
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ia.out_valid, ia.in_ready, ia.out_last, ia.frame_done, ia.out_x, ia.out_y} !== 10'b0100_000_000) begin
          n_err++;
          $display("FAIL abort_reset got vld=%b rdy=%b last=%b done=%b x=%0d y=%0d want 0 1 0 0 0 0",
                   ia.out_valid, ia.in_ready, ia.out_last, ia.frame_done, ia.out_x, ia.out_y);
        end
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        cycles = cyc;
        return;
      end
      cap[pos] = got;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = cyc[0];
        default: ready = 1'($urandom % 2);
      endcase
      ia.out_ready = ready;
      ia.in_valid  = 1'($urandom % 2);
      ia.in_data   = 1'($urandom % 2);
      if (ready) pos++;
      cyc++;
    end
    n_vec++;
    if (pos < 64) begin n_err++; $display("FAIL scan_timeout got %0d windows want 64", pos); end
    @(negedge clk);
    ia.out_ready = 1'b0;
    ia.in_valid  = 1'b0;
    n_vec++;
    if ({ia.frame_done, ia.in_ready, ia.out_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL done_pulse got done/rdy/vld=%b%b%b want 110", ia.frame_done, ia.in_ready, ia.out_valid);
    end
    @(negedge clk);
    n_vec++;
    if (ia.frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_width got %b want 0", ia.frame_done);
    end
    cycles = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ia.in_ready, ia.out_valid, ia.out_last, ia.frame_done, ia.out_x, ia.out_y,
         ia.c, ia.l, ia.r, ia.u, ia.d, ia.lu, ia.ld, ia.ru, ia.rd} !== 19'b1000_000_000_000000000) begin
      n_err++;
      $display("FAIL reset_state got rdy=%b vld=%b last=%b done=%b x=%0d y=%0d", ia.in_ready,
               ia.out_valid, ia.out_last, ia.frame_done, ia.out_x, ia.out_y);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_blinker();
    int cyc;
    gw = 8; gh = 8;
    foreach (mf[i]) mf[i] = 1'b0;
    mf[2*8+3] = 1'b1; mf[3*8+3] = 1'b1; mf[4*8+3] = 1'b1;
    load_a(1'b0);
    scan_a(0, -1, cyc);
    n_vec += 3;
    if (cap[3*8+2] !== 9'b001000011) begin
      n_err++; $display("FAIL blinker_23 got %b want 001000011", cap[3*8+2]);
    end
    if (cap[3*8+3] !== 9'b100110000) begin
      n_err++; $display("FAIL blinker_33 got %b want 100110000", cap[3*8+3]);
    end
    if (cyc !== 64) begin
      n_err++; $display("FAIL blinker_cycles got %0d want 64", cyc);
    end
  endtask

  task automatic test_boundary();
    int cyc;
    foreach (mf[i]) mf[i] = 1'b0;
    mf[63] = 1'b1;
    load_a(1'b0);
    scan_a(0, -1, cyc);
    n_vec++;
`ifdef LIFE_WRAP_EN
    if (cap[0] !== 9'b000001000) begin
      n_err++; $display("FAIL boundary_00 got %b want 000001000", cap[0]);
    end
`else
    if (cap[0] !== 9'b000000000) begin
      n_err++; $display("FAIL boundary_00 got %b want 000000000", cap[0]);
    end
`endif
  endtask

  task automatic test_backpressure();
    int cyc;
    foreach (mf[i]) mf[i] = 1'($urandom % 2);
    load_a(1'b0);
    scan_a(1, -1, cyc);
    n_vec++;
    if (cyc !== 128) begin
      n_err++; $display("FAIL bp_cycles got %0d want 128", cyc);
    end
    foreach (mf[i]) mf[i] = 1'($urandom % 2);
    load_a(1'b0);
    scan_a(2, -1, cyc);
  endtask

  task automatic test_load_gaps();
    int cyc;
    foreach (mf[i]) mf[i] = 1'($urandom % 2);
    load_a(1'b1);
    scan_a(0, -1, cyc);
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    foreach (mf[i]) mf[i] = 1'($urandom % 2);
    load_a(1'b0);
    scan_a(0, 2*8+4, cyc);
    foreach (mf[i]) mf[i] = 1'b1;
    load_a(1'b0);
    scan_a(0, -1, cyc);
    n_vec++;
    if (cap[3*8+3] !== 9'h1FF) begin
      n_err++; $display("FAIL ones_33 got %b want 111111111", cap[3*8+3]);
    end
  endtask

  task automatic test_non_pow2();
    int pos = 0;
    bit [8:0] got;
    gw = 5; gh = 3;
    for (int i = 0; i < 15; i++) mf[i] = 1'($urandom % 2);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_vec++;
      if ({ib.in_ready, ib.out_valid} !== 2'b10) begin
        n_err++; $display("FAIL np2_load k=%0d got rdy/vld=%b%b want 10", k, ib.in_ready, ib.out_valid);
      end
      ib.in_valid = 1'b1;
      ib.in_data  = mf[k];
    end
    while (pos < 15) begin
      @(negedge clk);
      ib.in_valid  = 1'b0;
      ib.out_ready = 1'b1;
      got = {ib.c, ib.l, ib.r, ib.u, ib.d, ib.lu, ib.ld, ib.ru, ib.rd};
      n_vec += 3;
      if ({ib.out_valid, ib.out_last} !== {1'b1, pos == 14}) begin
        n_err++; $display("FAIL np2_status pos=%0d got vld=%b last=%b", pos, ib.out_valid, ib.out_last);
      end
      if (ib.out_x !== 3'(pos % 5) || ib.out_y !== 2'(pos / 5)) begin
        n_err++; $display("FAIL np2_xy got (%0d,%0d) want (%0d,%0d)", ib.out_x, ib.out_y, pos % 5, pos / 5);
      end
      if (got !== ref_win(pos % 5, pos / 5)) begin
        n_err++; $display("FAIL np2_win pos=%0d got %b want %b", pos, got, ref_win(pos % 5, pos / 5));
      end
      pos++;
    end
    @(negedge clk);
    ib.out_ready = 1'b0;
    n_vec++;
    if ({ib.frame_done, ib.in_ready, ib.out_valid} !== 3'b110) begin
      n_err++; $display("FAIL np2_done got done/rdy/vld=%b%b%b want 110", ib.frame_done, ib.in_ready, ib.out_valid);
    end
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.in_data = 1'b0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_data = 1'b0; ib.out_ready = 1'b0;
    test_reset();
    test_blinker();
    test_boundary();
    test_backpressure();
    test_load_gaps();
    test_reset_mid_scan();
    test_non_pow2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
